// File: rtl/idex_skid_pipe.sv
// ID/EX pipeline register with valid/ready handshake, optional two-entry skid
// buffer, flush-to-bubble, and a saturating stall-cycle counter.
module idex_skid_pipe #(
   parameter int unsigned       CTRL_W   = 24,
   parameter int unsigned       DATA_W   = 111,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0,
   parameter bit                SKID     = 1'b1,
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cycles
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CTRL_W-1:0]  mainCtrl_q, mainCtrl_d;
   logic [DATA_W-1:0]  mainData_q, mainData_d;
   logic [CTRL_W-1:0]  skidCtrl_q, skidCtrl_d;
   logic [DATA_W-1:0]  skidData_q, skidData_d;
   logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
   logic               inFire;
   logic               outFire;

   assign out_valid = (state_q != EMPTY);
   assign inFire    = in_valid && in_ready;
   assign outFire   = out_valid && out_ready;

   // Control bundle is forced to the bubble value when nothing is held, so
   // EX never acts on stale write enables.
   assign out_ctrl     = out_valid ? mainCtrl_q : CTRL_RST;
   assign out_data     = mainData_q;
   assign occupancy    = state_q;
   assign stall_cycles = stallCnt_q;

   always_comb begin
      state_d    = state_q;
      mainCtrl_d = mainCtrl_q;
      mainData_d = mainData_q;
      skidCtrl_d = skidCtrl_q;
      skidData_d = skidData_q;
      if (flush) begin
         // Any same-edge output transfer already happened at EX; an input
         // transfer is dropped because upstream is flushed too.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (inFire) begin
                  state_d    = ONE;
                  mainCtrl_d = in_ctrl;
                  mainData_d = in_data;
               end
            end
            ONE: begin
               if (inFire && outFire) begin
                  mainCtrl_d = in_ctrl;
                  mainData_d = in_data;
               end else if (inFire) begin
                  // Only reachable with the skid entry present.
                  state_d    = TWO;
                  skidCtrl_d = in_ctrl;
                  skidData_d = in_data;
               end else if (outFire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (outFire) begin
                  state_d    = ONE;
                  mainCtrl_d = skidCtrl_q;
                  mainData_d = skidData_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (out_valid && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
         stallCnt_d = stallCnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= EMPTY;
         mainCtrl_q <= CTRL_RST;
         mainData_q <= '0;
         skidCtrl_q <= CTRL_RST;
         skidData_q <= '0;
         stallCnt_q <= '0;
      end else begin
         state_q    <= state_d;
         mainCtrl_q <= mainCtrl_d;
         mainData_q <= mainData_d;
         skidCtrl_q <= skidCtrl_d;
         skidData_q <= skidData_d;
         stallCnt_q <= stallCnt_d;
      end
   end

   generate
      if (SKID) begin : gSkid
         // Registered ready: cuts the out_ready -> in_ready path.
         logic inReady_q;
         always_ff @(posedge CLOCK) begin
            if (RESET) begin
               inReady_q <= 1'b0;
            end else begin
               inReady_q <= (state_d != TWO);
            end
         end
         assign in_ready = inReady_q;
      end else begin : gNoSkid
         assign in_ready = (state_q == EMPTY) || out_ready;
      end
   endgenerate

endmodule

// File: tb/tb_idex_skid_pipe.sv
// Directed bench for idex_skid_pipe: a SKID=1 instance with a narrow stall
// counter and a SKID=0 instance, checked against hand-computed values.
module tb_idex_skid_pipe;

   localparam int unsigned CW  = 8;
   localparam int unsigned DW  = 16;
   localparam logic [CW-1:0] RST_CTRL = 8'h5A;

   logic clock = 1'b0;
   logic reset;

   // SKID=1 instance signals
   logic          flush, inValid, inReady, outValid, outReady;
   logic [CW-1:0] inCtrl, outCtrl;
   logic [DW-1:0] inData, outData;
   logic [1:0]    occ;
   logic [3:0]    stall;

   // SKID=0 instance signals
   logic          flush0, inValid0, inReady0, outValid0, outReady0;
   logic [CW-1:0] inCtrl0, outCtrl0;
   logic [DW-1:0] inData0, outData0;
   logic [1:0]    occ0;
   logic [15:0]   stall0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   idex_skid_pipe #(
      .CTRL_W(CW), .DATA_W(DW), .CTRL_RST(RST_CTRL), .SKID(1'b1), .CNT_W(4)
   ) dut (
      .CLOCK(clock), .RESET(reset), .flush(flush),
      .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
      .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
      .occupancy(occ), .stall_cycles(stall)
   );

   idex_skid_pipe #(
      .CTRL_W(CW), .DATA_W(DW), .CTRL_RST(RST_CTRL), .SKID(1'b0), .CNT_W(16)
   ) dut0 (
      .CLOCK(clock), .RESET(reset), .flush(flush0),
      .in_valid(inValid0), .in_ready(inReady0), .in_ctrl(inCtrl0), .in_data(inData0),
      .out_valid(outValid0), .out_ready(outReady0), .out_ctrl(outCtrl0), .out_data(outData0),
      .occupancy(occ0), .stall_cycles(stall0)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                input logic rdy, input logic fl);
      inValid  = valid;
      inData   = data;
      inCtrl   = data[7:0] ^ 8'hC3;
      outReady = rdy;
      flush    = fl;
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      flush0 = 1'b0; inValid0 = 1'b0; inCtrl0 = '0; inData0 = '0; outReady0 = 1'b0;

      // Reset state
      tick(); tick();
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_ctrl", outCtrl, RST_CTRL);
      checkOutput("rst_out_data", outData, 0);
      checkOutput("rst_occ", occ, 0);
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_in_ready", inReady, 0);
      reset = 1'b0;
      tick();
      checkOutput("rst_release_in_ready", inReady, 1);

      // Streaming, out_ready held high
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1'b1, 16'(k), 1'b1, 1'b0);
         tick();
         checkOutput($sformatf("stream_data%0d", k), outData, k);
         checkOutput($sformatf("stream_ctrl%0d", k), outCtrl, 32'(k) ^ 32'hC3);
         checkOutput($sformatf("stream_occ%0d", k), occ, 1);
      end
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
      checkOutput("stream_drain_valid", outValid, 0);
      checkOutput("stream_drain_ctrl", outCtrl, RST_CTRL);
      checkOutput("stream_stall", stall, 0);

      // Back-pressure: A loaded, B caught in skid, C held upstream
      applyStimulus(1'b1, 16'h000A, 1'b1, 1'b0);
      tick();
      checkOutput("bp_A_loaded", outData, 16'h000A);
      applyStimulus(1'b1, 16'h000B, 1'b0, 1'b0);
      tick();
      checkOutput("bp_in_ready_low", inReady, 0);
      checkOutput("bp_occ2", occ, 2);
      checkOutput("bp_hold_A", outData, 16'h000A);
      applyStimulus(1'b1, 16'h000C, 1'b0, 1'b0);
      tick(); tick();
      checkOutput("bp_stall3", stall, 3);
      checkOutput("bp_still_A", outData, 16'h000A);
      applyStimulus(1'b1, 16'h000C, 1'b1, 1'b0);
      tick();
      checkOutput("bp_out_B", outData, 16'h000B);
      checkOutput("bp_ready_back", inReady, 1);
      tick();
      checkOutput("bp_out_C", outData, 16'h000C);
      checkOutput("bp_ctrl_C", outCtrl, 32'h0C ^ 32'hC3);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      tick();
      checkOutput("bp_drained", outValid, 0);
      checkOutput("bp_stall_kept", stall, 3);

      // Flush with a full buffer while D is offered
      applyStimulus(1'b1, 16'h0011, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0);
      tick();
      checkOutput("fl_occ2", occ, 2);
      applyStimulus(1'b1, 16'h00DD, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("fl_valid", outValid, 0);
      checkOutput("fl_ctrl", outCtrl, RST_CTRL);
      checkOutput("fl_occ0", occ, 0);
      checkOutput("fl_in_ready", inReady, 1);
      checkOutput("fl_data_held", outData, 16'h0011);
      checkOutput("fl_stall", stall, 5);
      tick();
      checkOutput("fl_D_absent", outValid, 0);

      // Flush beats an accepted input from EMPTY
      applyStimulus(1'b1, 16'h00EE, 1'b1, 1'b1);
      tick();
      checkOutput("fl_in_drop", outValid, 0);

      // Flush coincident with an output transfer
      applyStimulus(1'b1, 16'h0044, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      checkOutput("flo_present_valid", outValid, 1);
      checkOutput("flo_present_data", outData, 16'h0044);
      tick();
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("flo_bubble", outValid, 0);
      checkOutput("flo_bubble_ctrl", outCtrl, RST_CTRL);

      // Saturation of the 4-bit stall counter, then reset mid-stall
      applyStimulus(1'b1, 16'h0066, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      checkOutput("sat_14", stall, 14);
      tick();
      checkOutput("sat_15", stall, 15);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("sat_hold", stall, 15);
      reset = 1'b1;
      tick();
      checkOutput("mid_rst_valid", outValid, 0);
      checkOutput("mid_rst_ctrl", outCtrl, RST_CTRL);
      checkOutput("mid_rst_data", outData, 0);
      checkOutput("mid_rst_occ", occ, 0);
      checkOutput("mid_rst_stall", stall, 0);
      checkOutput("mid_rst_in_ready", inReady, 0);
      reset = 1'b0;
      tick();
      checkOutput("mid_rst_release", inReady, 1);

      // SKID=0: combinational ready follows out_ready
      inValid0 = 1'b1; inData0 = 16'h0050; inCtrl0 = 8'h50; outReady0 = 1'b1;
      #1;
      checkOutput("s0_empty_ready", inReady0, 1);
      tick();
      checkOutput("s0_loaded", outData0, 16'h0050);
      inData0 = 16'h0051; inCtrl0 = 8'h51; outReady0 = 1'b0;
      #1;
      checkOutput("s0_ready_low", inReady0, 0);
      tick();
      checkOutput("s0_held", outData0, 16'h0050);
      checkOutput("s0_stall", stall0, 1);
      outReady0 = 1'b1;
      #1;
      checkOutput("s0_ready_high", inReady0, 1);
      tick();
      checkOutput("s0_replaced", outData0, 16'h0051);
      checkOutput("s0_replaced_ctrl", outCtrl0, 8'h51);
      checkOutput("s0_occ1", occ0, 1);
      inValid0 = 1'b0;
      tick();
      checkOutput("s0_empty", occ0, 0);
      checkOutput("s0_bubble_ctrl", outCtrl0, RST_CTRL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
